// File: rtl/mode_command_tx.sv
// UART transmitter for the 3-byte mode command 'M', <rate char>, 'F' (8N1, LSB first).
// Define MODE_TX_CRLF_EN to append CR (0x0D) and LF (0x0A) after the final 'F'.
module mode_command_tx #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter bit          LOWERCASE    = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_send,
  input  logic [1:0] i_rate,
  output logic       o_tx,
  output logic       o_busy,
  output logic       o_done
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
`ifdef MODE_TX_CRLF_EN
  localparam int unsigned IW     = 3;
  localparam int unsigned NBYTES = 5;
`else
  localparam int unsigned IW     = 2;
  localparam int unsigned NBYTES = 3;
`endif
  localparam logic [IW-1:0] LAST_IDX  = IW'(NBYTES - 1);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    rate_q, rate_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          baud_end;

  function automatic logic [7:0] rate_char(input logic [1:0] rate);
    case (rate)
      2'b00:   return 8'h31;
      2'b01:   return 8'h35;
      2'b10:   return 8'h41;
      default: return 8'h3F;
    endcase
  endfunction

  function automatic logic [7:0] byte_at(input logic [IW-1:0] idx, input logic [7:0] rate);
    case (int'(idx))
      0:       return LOWERCASE ? 8'h6D : 8'h4D;
      1:       return rate;
      2:       return LOWERCASE ? 8'h66 : 8'h46;
`ifdef MODE_TX_CRLF_EN
      3:       return 8'h0D;
      4:       return 8'h0A;
`endif
      default: return 8'hFF;
    endcase
  endfunction

  assign baud_end = (baud_q == BAUD_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      rate_q  <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      rate_q  <= rate_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Line level is registered from the current state, so o_tx, o_busy fall and
  // o_done all trail the FSM by one cycle; IDLE with busy_q set is that trailing cycle.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    rate_d  = rate_q;
    tx_d    = 1'b1;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (busy_q) begin
          busy_d = 1'b0;
          done_d = 1'b1;
        end else if (i_send && !done_q) begin
          rate_d  = rate_char(i_rate);
          idx_d   = '0;
          shift_d = byte_at('0, rate_char(i_rate));
          baud_d  = '0;
          busy_d  = 1'b1;
          state_d = START;
        end
      end
      START: begin
        tx_d = 1'b0;
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DATA: begin
        tx_d = shift_q[0];
        if (baud_end) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (baud_end) begin
          baud_d = '0;
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + 1'b1;
            shift_d = byte_at(idx_q + 1'b1, rate_q);
            state_d = START;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_tx   = tx_q;
  assign o_busy = busy_q;
  assign o_done = done_q;

endmodule
